// File: rtl/tenyr_mem_pkg.sv
// Shared types and default widths for the tenyr memory-port arbiter.
package tenyr_mem_pkg;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CORE  = 1'b0,
        REQ_DEBUG = 1'b1
    } requester_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares tenyr memory port 0 between the core operand path (C) and the debug/loader port (D),
// one transaction at a time, with core priority bounded by a starvation counter.
module mem_port_arbiter
    import tenyr_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              c_req,
    input  logic              c_rw,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_enable,
    output logic              m_rw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output arb_state_t        arb_state
);

    localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    // Handshake: a requester holds req (with rw/addr/wdata stable) until it sees gnt.
    // gnt is combinational, only in an IDLE cycle, and the request is taken at that
    // cycle's closing edge. done pulses for one cycle after the access; rdata is
    // valid from the done cycle until that requester's next read completes.

    arb_state_t           state;
    arb_state_t           state_next;
    requester_t           owner;
    logic [LAT_W-1:0]     lat_cnt;
    logic [STARVE_W-1:0]  starve_cnt;
    logic                 arb_open;
    logic                 d_force;
    logic                 lat_last;
    logic                 granted;

    always_comb begin
        state_next = state;
        arb_open   = (state == IDLE) && reset_n;
        d_force    = (starve_cnt == STARVE_W'(STARVE_MAX)) && d_req;
        c_gnt      = arb_open && c_req && !d_force;
        d_gnt      = arb_open && d_req && (d_force || !c_req);
        granted    = c_gnt || d_gnt;
        lat_last   = (lat_cnt == LAT_W'(LATENCY - 1));
        case (state)
            IDLE:    if (granted) state_next = BUSY;
            BUSY:    if (lat_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transaction fields are captured once, at the grant edge, and held afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner   <= REQ_CORE;
            m_rw    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (d_gnt) begin
            owner   <= REQ_DEBUG;
            m_rw    <= d_rw;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
        end else if (c_gnt) begin
            owner   <= REQ_CORE;
            m_rw    <= c_rw;
            m_addr  <= c_addr;
            m_wdata <= c_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_enable <= 1'b0;
            lat_cnt  <= '0;
        end else if (granted) begin
            m_enable <= 1'b1;
            lat_cnt  <= '0;
        end else if (state == BUSY) begin
            if (lat_last) begin
                m_enable <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_rdata <= '0;
            d_rdata <= '0;
        end else if ((state == BUSY) && lat_last && !m_rw) begin
            if (owner == REQ_DEBUG) begin
                d_rdata <= m_rdata;
            end else begin
                c_rdata <= m_rdata;
            end
        end
    end

    // Counts core wins that D had to watch; reaching STARVE_MAX hands D the next slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!d_req || d_gnt) begin
            starve_cnt <= '0;
        end else if (c_gnt && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    assign c_done    = (state == DONE) && (owner == REQ_CORE);
    assign d_done    = (state == DONE) && (owner == REQ_DEBUG);
    assign arb_state = state;

endmodule
